// File: rtl/ej32_pkg.sv
// Shared FSM state encoding and serial frame constants for the EJ32 output transmitter.
// Defining EJ32_TX_PARITY_EN adds a PARITY state between DATA and STOP.
package ej32_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_START,
        S_DATA,
`ifdef EJ32_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ej32_obuf_tx_if.sv
// RAM read port used by the output-buffer transmitter: request/address out, grant/data back.
// The master side issues reads; read data is valid one cycle after an accepted request.
interface ej32_obuf_tx_if #(
    parameter int unsigned ASZ = 17
);
    logic           mem_re;
    logic [ASZ-1:0] mem_a;
    logic           mem_gnt;
    logic [7:0]     mem_d;

    modport master (output mem_re, output mem_a, input mem_gnt, input mem_d);
    modport slave  (input mem_re, input mem_a, output mem_gnt, output mem_d);
endinterface

// File: rtl/ej32_baud_gen.sv
// Bit-timing counter: pulses tick once every BAUD_DIV cycles while clr is low.
// clr holds the count at zero so the next bit period starts fresh.
module ej32_baud_gen #(
    parameter int unsigned BAUD_DIV = 208
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ej32_obuf_tx.sv
// Drains len bytes from the RAM output ring (starting at offset head) onto a UART line.
// Frames are 8N1 by default; defining EJ32_TX_PARITY_EN inserts an even-parity bit.
module ej32_obuf_tx
    import ej32_pkg::*;
#(
    parameter int unsigned OBUF     = 'h1400,
    parameter int unsigned ASZ      = 17,
    parameter int unsigned OB_SZ    = 1024,
    parameter int unsigned BAUD_DIV = 208
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(OB_SZ)-1:0] head,
    input  logic [$clog2(OB_SZ):0]   len,
    ej32_obuf_tx_if.master           mem,
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned OW = $clog2(OB_SZ);
    localparam int unsigned BW = $clog2(DATA_BITS);

    state_t              state, state_nx;
    logic [OW-1:0]       head_q;
    logic [OW:0]         len_q;
    logic [OW:0]         idx;
    logic [BW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [OW-1:0]       offset;
    logic                tick;
    logic                bclr;
`ifdef EJ32_TX_PARITY_EN
    logic                par;
`endif

    // Truncation to OW bits gives the modulo-OB_SZ ring wrap.
    assign offset = head_q + idx[OW-1:0];

    ej32_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (bclr),
        .tick (tick)
    );

    always_comb begin
        state_nx   = state;
        mem.mem_re = 1'b0;
        mem.mem_a  = '0;
        tx         = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        bclr       = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = (len != '0) ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                busy       = 1'b1;
                mem.mem_re = 1'b1;
                mem.mem_a  = ASZ'(OBUF) + ASZ'(offset);
                if (mem.mem_gnt) state_nx = S_WAIT;
            end
            S_WAIT: begin
                busy     = 1'b1;
                state_nx = S_START;
            end
            S_START: begin
                busy = 1'b1;
                bclr = 1'b0;
                tx   = 1'b0;
                if (tick) state_nx = S_DATA;
            end
            S_DATA: begin
                busy = 1'b1;
                bclr = 1'b0;
                tx   = shreg[0];
`ifdef EJ32_TX_PARITY_EN
                if (tick && bit_cnt == BW'(DATA_BITS - 1)) state_nx = S_PARITY;
            end
            S_PARITY: begin
                busy = 1'b1;
                bclr = 1'b0;
                tx   = par;
                if (tick) state_nx = S_STOP;
`else
                if (tick && bit_cnt == BW'(DATA_BITS - 1)) state_nx = S_STOP;
`endif
            end
            S_STOP: begin
                busy = 1'b1;
                bclr = 1'b0;
                if (tick && bit_cnt == BW'(STOP_BITS - 1))
                    state_nx = ((idx + 1'b1) < len_q) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            head_q  <= '0;
            len_q   <= '0;
            idx     <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nx;
            // Only an idle transmitter accepts a new request; start while busy is dropped.
            if (state == S_IDLE && start && len != '0) begin
                head_q <= head;
                len_q  <= len;
                idx    <= '0;
            end
            if (state == S_STOP && state_nx != S_STOP) idx <= idx + 1'b1;
            if (state_nx != state) bit_cnt <= '0;
            else if (tick)         bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_WAIT) begin
            shreg <= mem.mem_d;
`ifdef EJ32_TX_PARITY_EN
            par   <= even_parity(mem.mem_d);
`endif
        end else if (state == S_DATA && tick) begin
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
        end
    end
endmodule

// File: tb/tb_ej32_obuf_tx.sv
// Bench for ej32_obuf_tx: table of ring transfers, hand-written corner sequences and random transfers,
// checked cycle-by-cycle against frames built from the ring contents.
module tb_ej32_obuf_tx;
    localparam int unsigned D     = 4;
    localparam int unsigned OBUF  = 'h1400;
    localparam int unsigned ASZ   = 17;
    localparam int unsigned OB_SZ = 1024;
`ifdef EJ32_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  head;
    logic [10:0] len;
    logic        tx, busy, done;

    ej32_obuf_tx_if #(.ASZ(ASZ)) mem ();

    ej32_obuf_tx #(.OBUF(OBUF), .ASZ(ASZ), .OB_SZ(OB_SZ), .BAUD_DIV(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .head  (head),
        .len   (len),
        .mem   (mem.master),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]     ram [OB_SZ];
    int             gnt_mode = 0;   // 0: always grant, 1: random grant, 2: withheld
    logic           rnd_bit = 1'b1;
    int             done_cnt = 0;
    int             re_viol = 0;
    int             d0;
    logic [ASZ-1:0] acc_q[$];
    logic [63:0]    frm_q[$];

    assign mem.mem_gnt = (gnt_mode == 0) || (gnt_mode == 1 && rnd_bit);

    always @(posedge clk) begin
        #2 rnd_bit = 1'($urandom_range(0, 1));
    end

    // RAM model and bus/done monitors
    always @(posedge clk) begin
        if (mem.mem_re && mem.mem_gnt) begin
            acc_q.push_back(mem.mem_a);
            mem.mem_d <= ram[10'(mem.mem_a - ASZ'(OBUF))];
        end
        if (done) done_cnt <= done_cnt + 1;
        if (mem.mem_re && !busy) re_viol <= re_viol + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line level for every cycle of one frame, index 0 = first start-bit cycle.
    function automatic logic [63:0] frame_of(input logic [7:0] b);
        logic [63:0]   v;
        logic [FB-1:0] bits;
        v = '0;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef EJ32_TX_PARITY_EN
        bits[9] = ^b;
`endif
        bits[FB-1] = 1'b1;
        for (int c = 0; c < FB * int'(D); c++) v[c] = bits[c / int'(D)];
        return v;
    endfunction

    task automatic issue(input int h, input int n);
        acc_q.delete();
        frm_q.delete();
        d0 = done_cnt;
        head  = 10'(h);
        len   = 11'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rx_check(input string name, input int h, input int n);
        int          wait_c;
        int          stall;
        bit          gap_bad;
        bit          addr_ok;
        logic [63:0] obs;
        logic [7:0]  b;
        if (n == 0) begin
            chk({name, " done pulse"}, 64'(done), 64'(1));
            chk({name, " busy low"}, 64'(busy), 64'(0));
            chk({name, " tx idle"}, 64'(tx), 64'(1));
            @(negedge clk);
            chk({name, " done one cycle"}, 64'(done), 64'(0));
            chk({name, " no reads"}, 64'(acc_q.size()), 64'(0));
            chk({name, " done count"}, 64'(done_cnt - d0), 64'(1));
            return;
        end
        chk({name, " busy"}, 64'(busy), 64'(1));
        gap_bad = 1'b0;
        for (int k = 0; k < n; k++) begin
            wait_c = 0;
            stall  = 0;
            while (tx !== 1'b0 && wait_c < 2000) begin
                if (mem.mem_re && !mem.mem_gnt) stall++;
                @(negedge clk);
                wait_c++;
            end
            if (wait_c >= 2000) begin
                chk({name, " frame timeout"}, 64'(wait_c), 64'(0));
                return;
            end
            if (k > 0 && wait_c > 3 + stall) gap_bad = 1'b1;
            obs = '0;
            for (int c = 0; c < FB * int'(D); c++) begin
                obs[c] = tx;
                @(negedge clk);
            end
            frm_q.push_back(obs);
            b = ram[(h + k) % OB_SZ];
            chk($sformatf("%s frame %0d", name, k), obs, frame_of(b));
        end
        chk({name, " done after stop"}, 64'(done), 64'(1));
        chk({name, " busy cleared"}, 64'(busy), 64'(0));
        @(negedge clk);
        chk({name, " done one cycle"}, 64'(done), 64'(0));
        chk({name, " done count"}, 64'(done_cnt - d0), 64'(1));
        if (n > 1) chk({name, " inter-byte gap"}, 64'(gap_bad), 64'(0));
        addr_ok = (acc_q.size() == n);
        for (int k = 0; k < n && addr_ok; k++)
            if (acc_q[k] !== ASZ'(OBUF + ((h + k) % OB_SZ))) addr_ok = 1'b0;
        chk({name, " address sequence"}, 64'(addr_ok), 64'(1));
    endtask

    typedef struct {
        int             h;
        int             n;
        int             mode;
        logic [ASZ-1:0] a_first;
        logic [ASZ-1:0] a_last;
    } vec_t;

    vec_t        tbl [6];
    logic [ASZ-1:0] a0;
    bit          hold_ok;
    logic [8:0]  seq9;
    int          wc;

    initial begin
        tbl[0] = '{0,    1,    0, 17'h1400, 17'h1400};
        tbl[1] = '{1022, 3,    0, 17'h17FE, 17'h1400};
        tbl[2] = '{1023, 2,    1, 17'h17FF, 17'h1400};
        tbl[3] = '{5,    4,    1, 17'h1405, 17'h1408};
        tbl[4] = '{0,    0,    0, 17'h0,    17'h0};
        tbl[5] = '{512,  1024, 0, 17'h1600, 17'h15FF};

        for (int i = 0; i < int'(OB_SZ); i++) ram[i] = 8'($urandom);
        ram[0] = 8'hA5;

        rst = 1'b1; start = 1'b0; head = '0; len = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset tx", 64'(tx), 64'(1));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset mem_re", 64'(mem.mem_re), 64'(0));
        chk("reset mem_a", 64'(mem.mem_a), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            gnt_mode = tbl[t].mode;
            issue(tbl[t].h, tbl[t].n);
            rx_check($sformatf("vec%0d", t), tbl[t].h, tbl[t].n);
            if (tbl[t].n > 0 && acc_q.size() > 0) begin
                chk($sformatf("vec%0d first addr", t), 64'(acc_q[0]), 64'(tbl[t].a_first));
                chk($sformatf("vec%0d last addr", t), 64'(acc_q[acc_q.size()-1]), 64'(tbl[t].a_last));
            end
            if (t == 0 && frm_q.size() > 0) begin
                for (int bi = 0; bi < 9; bi++) seq9[bi] = frm_q[0][bi * int'(D)];
                chk("A5 bit sequence", 64'(seq9), 64'(9'h14A));
            end
            repeat (3) @(negedge clk);
        end
        gnt_mode = 0;

        // grant withheld in FETCH; a start pulse meanwhile must be ignored
        ram[7] = 8'h3C;
        gnt_mode = 2;
        issue(7, 1);
        a0 = mem.mem_a;
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin head = 10'd0; len = 11'd5; start = 1'b1; end
            if (c == 5) start = 1'b0;
            if (mem.mem_re !== 1'b1 || mem.mem_a !== a0) hold_ok = 1'b0;
            @(negedge clk);
        end
        chk("stall hold", 64'(hold_ok), 64'(1));
        chk("stall addr", 64'(a0), 64'(17'h1407));
        gnt_mode = 0;
        rx_check("stall", 7, 1);
        repeat (3) @(negedge clk);

        // reset during DATA bit 3
        ram[20] = 8'h96; ram[21] = 8'h5A;
        issue(20, 2);
        wc = 0;
        while (tx !== 1'b0 && wc < 100) begin @(negedge clk); wc++; end
        chk("midreset frame seen", 64'(wc < 100), 64'(1));
        repeat (D + 3 * D + 1) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midreset tx", 64'(tx), 64'(1));
        chk("midreset busy", 64'(busy), 64'(0));
        chk("midreset mem_re", 64'(mem.mem_re), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("midreset no done", 64'(done_cnt - d0), 64'(0));
        chk("midreset line idle", 64'(tx), 64'(1));
        issue(20, 2);
        rx_check("after reset", 20, 2);
        repeat (3) @(negedge clk);

        // parity corner bytes (plain frames in the 8N1 build)
        ram[100] = 8'h07; ram[101] = 8'h03;
        issue(100, 2);
        rx_check("parity bytes", 100, 2);
`ifdef EJ32_TX_PARITY_EN
        if (frm_q.size() == 2) begin
            chk("parity of 07", 64'(frm_q[0][9 * D]), 64'(1));
            chk("parity of 03", 64'(frm_q[1][9 * D]), 64'(0));
        end
`endif
        repeat (3) @(negedge clk);

        // random transfers with random grant behaviour
        for (int r = 0; r < 8; r++) begin
            int h, n;
            h = int'($urandom_range(0, OB_SZ - 1));
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) ram[(h + k) % OB_SZ] = 8'($urandom);
            gnt_mode = int'($urandom_range(0, 1));
            issue(h, n);
            rx_check($sformatf("rand%0d", r), h, n);
            repeat (int'($urandom_range(1, 4))) @(negedge clk);
        end
        gnt_mode = 0;

        chk("mem_re only while busy", 64'(re_viol), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
